sgdmac_rd_arbiter: RTL and testbench
====================================

# sgdmac_rd_arbiter

Two-master round-robin arbiter that shares the DMAC's single AXI read port (AR and R channels) between the descriptor fetch unit (M0) and the SG read data engine (M1). It allows one outstanding burst at a time and holds the grant from AR handshake to the final R beat. R beats are routed back by the registered grant, not by RID. It also checks each burst's beat count against its ARLEN and flags mismatches.

## Interface
- RR_INIT, 0: master given priority first after reset (0 or 1).
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- m{0,1}_arid_i / araddr_i / arlen_i / arsize_i / arburst_i  in  4/32/4/3/2  per-master AR payload.
- m{0,1}_arvalid_i  in  1  per-master AR request.
- m{0,1}_arready_o  out  1  per-master AR accept.
- m{0,1}_rid_o / rdata_o / rresp_o / rlast_o  out  4/32/2/1  per-master R payload, broadcast from the port.
- m{0,1}_rvalid_o  out  1  R valid, asserted only toward the granted master.
- m{0,1}_rready_i  in  1  per-master R ready.
- arid_o / araddr_o / arlen_o / arsize_o / arburst_o  out  4/32/4/3/2  AR payload to the port.
- arvalid_o  out  1  AR valid to the port.
- arready_i  in  1  AR ready from the port.
- rid_i / rdata_i / rresp_i / rlast_i / rvalid_i  in  4/32/2/1/1  R channel from the port.
- rready_o  out  1  R ready to the port.
- busy_o  out  1  high in any state other than IDLE.
- len_err_o  out  1  sticky burst-length mismatch flag.
- len_err_clr_i  in  1  clears len_err_o.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE
  - If any m*_arvalid_i is high, latch grant, latch granted arlen into beat_left[4:0] = arlen + 1, then go to ADDR.
  - Round-robin: if both masters request, the master that is not last_gnt wins. last_gnt resets to ~RR_INIT, so RR_INIT wins the first tie.
  - A single requester always wins.
- ADDR
  - arvalid_o = granted m_arvalid_i. AR payload muxed from the granted master.
  - Granted m_arready_o = arready_i. The other master's arready is 0.
  - On handshake (arvalid_o & arready_i): go to DATA and set last_gnt = grant.
  - If the granted master drops arvalid before the handshake (a protocol violation), return to IDLE with no error.
- DATA
  - Granted m_rvalid_o = rvalid_i. rready_o = granted m_rready_i. The non-granted master sees rvalid 0.
  - Each R handshake decrements beat_left.
  - On handshake with rlast_i: return to IDLE. If beat_left != 1, set len_err_o.
  - On handshake without rlast_i while beat_left == 1 (an overrun): set len_err_o, stay in DATA, and keep beat_left saturated at 0 until rlast.
- Both AR ready outputs are 0 outside ADDR. rready_o and both m*_rvalid_o are 0 outside DATA.
- len_err_o: set has priority over len_err_clr_i in the same cycle.
- Reset (async, any state): state=IDLE, grant=RR_INIT, last_gnt=~RR_INIT, beat_left=0. All valid/ready outputs, busy_o and len_err_o are 0. Payload outputs are don't-care but are driven from master 0.

## Timing
- Arbitration is registered. A request in cycle N gives arvalid_o at N+1 at the earliest.
- After the last beat, a new grant takes effect at +1 cycle (IDLE) and AR at +2. Minimum gap between bursts: 2 cycles.
- AR and R paths are combinational passthrough muxes, with select from flops only. There is no payload buffering and zero added latency on R beats.
- A new request arriving during DATA waits and is arbitrated in the next IDLE cycle.
- Masters must hold AR payload stable while arvalid is high (AXI rule). The arbiter relies on this.

## Configuration
- SGDMAC_RD_ARB_FIXED_PRIO_EN defined: M0 (descriptor fetch) always wins ties and last_gnt is ignored. Descriptor fetch latency is bounded, but M1 can starve.
- Not defined: round-robin as described above. This is the default build.

## Test plan
- Single M1 request, addr 0x1000, arlen 15, arready held 1 -> arvalid_o at +1, 16 beats routed to M1 only, busy_o drops after the rlast beat, len_err_o=0.
- M0 and M1 request in the same cycle after reset with RR_INIT=0 -> M0 is granted first, then M1. Next tie goes to M0. Alternation confirmed over 4 bursts.
- M1 deasserts m1_rready_i for 3 cycles mid-burst -> rready_o=0 for those cycles, no beats lost, rdata order preserved.
- arlen 3 with rlast on beat 3 -> len_err_o=1 and returns to IDLE. len_err_clr_i pulse -> 0. Repeat with rlast on beat 5 -> len_err_o=1 and the state waits for rlast.
- rst_n asserted during DATA beat 7 of 16 -> all outputs go to reset values immediately. After release, a new M0 request is granted normally.
- With SGDMAC_RD_ARB_FIXED_PRIO_EN, both masters request continuously -> M0 is granted every burst and M1 is never granted.

Source files
------------

// File: rtl/sgdmac_rd_arbiter.sv
// Two-master read-port arbiter for the SG DMAC: one outstanding burst, grant held from AR to last R beat.
// Build option: define SGDMAC_RD_ARB_FIXED_PRIO_EN to give M0 fixed priority instead of round-robin.
module sgdmac_rd_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  m0_arid_i,
    input  logic [31:0] m0_araddr_i,
    input  logic [3:0]  m0_arlen_i,
    input  logic [2:0]  m0_arsize_i,
    input  logic [1:0]  m0_arburst_i,
    input  logic        m0_arvalid_i,
    output logic        m0_arready_o,
    output logic [3:0]  m0_rid_o,
    output logic [31:0] m0_rdata_o,
    output logic [1:0]  m0_rresp_o,
    output logic        m0_rlast_o,
    output logic        m0_rvalid_o,
    input  logic        m0_rready_i,
    input  logic [3:0]  m1_arid_i,
    input  logic [31:0] m1_araddr_i,
    input  logic [3:0]  m1_arlen_i,
    input  logic [2:0]  m1_arsize_i,
    input  logic [1:0]  m1_arburst_i,
    input  logic        m1_arvalid_i,
    output logic        m1_arready_o,
    output logic [3:0]  m1_rid_o,
    output logic [31:0] m1_rdata_o,
    output logic [1:0]  m1_rresp_o,
    output logic        m1_rlast_o,
    output logic        m1_rvalid_o,
    input  logic        m1_rready_i,
    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [3:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic        busy_o,
    output logic        len_err_o,
    input  logic        len_err_clr_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

    state_t     state_r, state_s;
    logic       grant_r, grant_s;
    logic       last_gnt_r, last_gnt_s;
    logic       len_err_r, len_err_s;
    logic [4:0] beat_left_r, beat_left_s;
    logic       win_s, sel_s, gnt_arvalid_s, ar_hs_s, r_hs_s, err_set_s;

    // Payload select comes from flops only; forced to M0 while idle so reset drives M0's payload.
    assign sel_s         = (state_r != IDLE) & grant_r;
    assign gnt_arvalid_s = grant_r ? m1_arvalid_i : m0_arvalid_i;

    assign arid_o    = sel_s ? m1_arid_i    : m0_arid_i;
    assign araddr_o  = sel_s ? m1_araddr_i  : m0_araddr_i;
    assign arlen_o   = sel_s ? m1_arlen_i   : m0_arlen_i;
    assign arsize_o  = sel_s ? m1_arsize_i  : m0_arsize_i;
    assign arburst_o = sel_s ? m1_arburst_i : m0_arburst_i;

    assign arvalid_o    = (state_r == ADDR) & gnt_arvalid_s;
    assign m0_arready_o = (state_r == ADDR) & ~grant_r & arready_i;
    assign m1_arready_o = (state_r == ADDR) &  grant_r & arready_i;

    assign rready_o    = (state_r == DATA) & (grant_r ? m1_rready_i : m0_rready_i);
    assign m0_rvalid_o = (state_r == DATA) & ~grant_r & rvalid_i;
    assign m1_rvalid_o = (state_r == DATA) &  grant_r & rvalid_i;

    assign m0_rid_o   = rid_i;
    assign m0_rdata_o = rdata_i;
    assign m0_rresp_o = rresp_i;
    assign m0_rlast_o = rlast_i;
    assign m1_rid_o   = rid_i;
    assign m1_rdata_o = rdata_i;
    assign m1_rresp_o = rresp_i;
    assign m1_rlast_o = rlast_i;

    assign ar_hs_s   = arvalid_o & arready_i;
    assign r_hs_s    = rvalid_i & rready_o;
    assign busy_o    = (state_r != IDLE);
    assign len_err_o = len_err_r;

    // Arbitration winner among current requesters.
    always_comb begin
        win_s = 1'b0;
        if (m0_arvalid_i && m1_arvalid_i) begin
`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
            win_s = 1'b0;
`else
            win_s = ~last_gnt_r;
`endif
        end else if (m1_arvalid_i) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Next-state, grant, beat counter and length-error logic.
    always_comb begin
        state_s     = state_r;
        grant_s     = grant_r;
        last_gnt_s  = last_gnt_r;
        beat_left_s = beat_left_r;
        err_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (m0_arvalid_i || m1_arvalid_i) begin
                    grant_s     = win_s;
                    beat_left_s = {1'b0, (win_s ? m1_arlen_i : m0_arlen_i)} + 5'd1;
                    state_s     = ADDR;
                end else begin
                    state_s = IDLE;
                end
            end
            ADDR: begin
                if (ar_hs_s) begin
                    state_s    = DATA;
                    last_gnt_s = grant_r;
                end else if (!gnt_arvalid_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ADDR;
                end
            end
            DATA: begin
                if (r_hs_s) begin
                    // Saturating count: an overrun parks at 0 until rlast arrives.
                    beat_left_s = (beat_left_r == 5'd0) ? 5'd0 : (beat_left_r - 5'd1);
                    if (rlast_i) begin
                        state_s   = IDLE;
                        err_set_s = (beat_left_r != 5'd1);
                    end else begin
                        err_set_s = (beat_left_r <= 5'd1);
                    end
                end else begin
                    beat_left_s = beat_left_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (err_set_s) begin
            len_err_s = 1'b1;
        end else if (len_err_clr_i) begin
            len_err_s = 1'b0;
        end else begin
            len_err_s = len_err_r;
        end
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            grant_r     <= RR_INIT;
            last_gnt_r  <= ~RR_INIT;
            beat_left_r <= 5'd0;
            len_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            grant_r     <= grant_s;
            last_gnt_r  <= last_gnt_s;
            beat_left_r <= beat_left_s;
            len_err_r   <= len_err_s;
        end
    end

endmodule

// File: tb/tb_sgdmac_rd_arbiter.sv
// Scoreboard bench for sgdmac_rd_arbiter: a port-side slave model pushes expected R beats, a monitor checks routing.
module tb_sgdmac_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m0_arid_i, m1_arid_i, arid_o, rid_i, m0_rid_o, m1_rid_o;
    logic [31:0] m0_araddr_i, m1_araddr_i, araddr_o, rdata_i, m0_rdata_o, m1_rdata_o;
    logic [3:0]  m0_arlen_i, m1_arlen_i, arlen_o;
    logic [2:0]  m0_arsize_i, m1_arsize_i, arsize_o;
    logic [1:0]  m0_arburst_i, m1_arburst_i, arburst_o, rresp_i, m0_rresp_o, m1_rresp_o;
    logic        m0_arvalid_i, m1_arvalid_i, m0_arready_o, m1_arready_o;
    logic        m0_rlast_o, m1_rlast_o, m0_rvalid_o, m1_rvalid_o, m0_rready_i, m1_rready_i;
    logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o, busy_o, len_err_o, len_err_clr_i;

    typedef struct {
        int          m;
        logic [31:0] d;
    } sb_t;

    sb_t         sb_q[$];
    sb_t         mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [3:0]  ids [2];
    logic [31:0] addrs [2];
    logic [3:0]  lens [2];

    always #5 clk = ~clk;

    sgdmac_rd_arbiter #(.RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arid_i(m0_arid_i), .m0_araddr_i(m0_araddr_i), .m0_arlen_i(m0_arlen_i),
        .m0_arsize_i(m0_arsize_i), .m0_arburst_i(m0_arburst_i), .m0_arvalid_i(m0_arvalid_i),
        .m0_arready_o(m0_arready_o), .m0_rid_o(m0_rid_o), .m0_rdata_o(m0_rdata_o),
        .m0_rresp_o(m0_rresp_o), .m0_rlast_o(m0_rlast_o), .m0_rvalid_o(m0_rvalid_o),
        .m0_rready_i(m0_rready_i),
        .m1_arid_i(m1_arid_i), .m1_araddr_i(m1_araddr_i), .m1_arlen_i(m1_arlen_i),
        .m1_arsize_i(m1_arsize_i), .m1_arburst_i(m1_arburst_i), .m1_arvalid_i(m1_arvalid_i),
        .m1_arready_o(m1_arready_o), .m1_rid_o(m1_rid_o), .m1_rdata_o(m1_rdata_o),
        .m1_rresp_o(m1_rresp_o), .m1_rlast_o(m1_rlast_o), .m1_rvalid_o(m1_rvalid_o),
        .m1_rready_i(m1_rready_i),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .busy_o(busy_o), .len_err_o(len_err_o), .len_err_clr_i(len_err_clr_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Monitor: every port-side R handshake must reach the expected master with the expected data.
    always @(negedge clk) begin
        if (rst_n && rvalid_i && rready_o) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", sb_q.size(), 1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("r_m0_valid", {31'd0, m0_rvalid_o}, {31'd0, (mon_e.m == 0)});
                check_eq("r_m1_valid", {31'd0, m1_rvalid_o}, {31'd0, (mon_e.m == 1)});
                check_eq("r_data", (mon_e.m == 1) ? m1_rdata_o : m0_rdata_o, mon_e.d);
            end
        end
    end

    task automatic set_req(input int m, input logic [31:0] a, input logic [3:0] l);
        addrs[m] = a;
        lens[m]  = l;
        if (m == 1) begin
            m1_araddr_i = a; m1_arlen_i = l; m1_arvalid_i = 1'b1;
        end else begin
            m0_araddr_i = a; m0_arlen_i = l; m0_arvalid_i = 1'b1;
        end
    endtask

    // Serve one burst as the port slave. rereq: 0 drop granted arvalid, 1 keep it, 2 drop both.
    task automatic serve(input int em, input int nbeats, input int stall_at, input int rereq,
                         input int rst_at, input int exp_lat, input logic exp_err);
        int          cnt;
        logic [31:0] d;
        cnt = 0;
        @(negedge clk);
        while (!arvalid_o && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("ar_valid", {31'd0, arvalid_o}, 32'd1);
        if (exp_lat >= 0) check_eq("ar_latency", cnt, exp_lat);
        check_eq("ar_id", {28'd0, arid_o}, {28'd0, ids[em]});
        check_eq("ar_addr", araddr_o, addrs[em]);
        check_eq("ar_len", {28'd0, arlen_o}, {28'd0, lens[em]});
        check_eq("ar_ready_gnt", {31'd0, (em == 1) ? m1_arready_o : m0_arready_o}, 32'd1);
        check_eq("ar_ready_other", {31'd0, (em == 1) ? m0_arready_o : m1_arready_o}, 32'd0);
        @(posedge clk); #1;
        if (rereq == 0) begin
            if (em == 1) m1_arvalid_i = 1'b0; else m0_arvalid_i = 1'b0;
        end else if (rereq == 2) begin
            m0_arvalid_i = 1'b0;
            m1_arvalid_i = 1'b0;
        end
        for (int b = 0; b < nbeats; b++) begin
            d        = $urandom;
            rvalid_i = 1'b1;
            rdata_i  = d;
            rid_i    = ids[em];
            rlast_i  = (b == nbeats - 1);
            sb_q.push_back('{m: em, d: d});
            if (b == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("rst_arvalid", {31'd0, arvalid_o}, 32'd0);
                check_eq("rst_m0_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
                check_eq("rst_m1_rvalid", {31'd0, m1_rvalid_o}, 32'd0);
                check_eq("rst_rready", {31'd0, rready_o}, 32'd0);
                check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
                check_eq("rst_len_err", {31'd0, len_err_o}, 32'd0);
                check_eq("rst_araddr_m0", araddr_o, m0_araddr_i);
                sb_q.delete();
                rvalid_i = 1'b0;
                rlast_i  = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
            if (b == stall_at) begin
                if (em == 1) m1_rready_i = 1'b0; else m0_rready_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_rready", {31'd0, rready_o}, 32'd0);
                    @(posedge clk); #1;
                end
                m0_rready_i = 1'b1;
                m1_rready_i = 1'b1;
            end
            cnt = 0;
            @(negedge clk);
            while (!rready_o && cnt < 20) begin
                cnt++;
                @(negedge clk);
            end
            check_eq("r_handshake", {31'd0, rready_o}, 32'd1);
            @(posedge clk); #1;
            if (b != nbeats - 1) check_eq("busy_mid", {31'd0, busy_o}, 32'd1);
        end
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        check_eq("busy_end", {31'd0, busy_o}, 32'd0);
        check_eq("len_err", {31'd0, len_err_o}, {31'd0, exp_err});
    endtask

    initial begin
        int em;
        ids[0] = 4'h3;
        ids[1] = 4'hA;
        rst_n = 1'b0;
        m0_arid_i = ids[0]; m0_araddr_i = 32'h0; m0_arlen_i = 4'd0;
        m0_arsize_i = 3'd2; m0_arburst_i = 2'b01; m0_arvalid_i = 1'b0; m0_rready_i = 1'b1;
        m1_arid_i = ids[1]; m1_araddr_i = 32'h0; m1_arlen_i = 4'd0;
        m1_arsize_i = 3'd2; m1_arburst_i = 2'b01; m1_arvalid_i = 1'b0; m1_rready_i = 1'b1;
        arready_i = 1'b1; rid_i = 4'd0; rdata_i = 32'd0; rresp_i = 2'b00;
        rlast_i = 1'b0; rvalid_i = 1'b0; len_err_clr_i = 1'b0;
        m0_araddr_i = 32'hDEAD_0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", {31'd0, busy_o}, 32'd0);
        check_eq("reset_arvalid", {31'd0, arvalid_o}, 32'd0);
        check_eq("reset_rready", {31'd0, rready_o}, 32'd0);
        check_eq("reset_len_err", {31'd0, len_err_o}, 32'd0);
        check_eq("reset_araddr_m0", araddr_o, m0_araddr_i);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_req(1, 32'h1000, 4'd15);
        serve(1, 16, -1, 0, -1, 1, 1'b0);

        set_req(1, 32'h1400, 4'd7);
        serve(1, 8, 3, 0, -1, -1, 1'b0);

        set_req(0, 32'h2000, 4'd3);
        serve(0, 3, -1, 0, -1, -1, 1'b1);
        len_err_clr_i = 1'b1;
        @(posedge clk); #1;
        len_err_clr_i = 1'b0;
        check_eq("len_err_clr", {31'd0, len_err_o}, 32'd0);
        set_req(0, 32'h3000, 4'd3);
        serve(0, 5, -1, 0, -1, -1, 1'b1);

        set_req(1, 32'h5000, 4'd15);
        serve(1, 16, -1, 0, 6, -1, 1'b0);

        set_req(0, 32'h6000, 4'd1);
        set_req(1, 32'h7000, 4'd2);
        for (int k = 0; k < 4; k++) begin
`ifdef SGDMAC_RD_ARB_FIXED_PRIO_EN
            em = 0;
`else
            em = k % 2;
`endif
            serve(em, int'(lens[em]) + 1, -1, (k == 3) ? 2 : 1, -1, -1, 1'b0);
        end

        set_req(0, 32'h8000, 4'd3);
        serve(0, 4, -1, 0, -1, 1, 1'b0);

        repeat (2) @(posedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
